// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (core, debug), the memory port and dmem_arbiter.
// The slave modport is the arbiter's view; master is the core/debug/memory side.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    // core load/store port
    logic                  c_req;
    logic                  c_we;
    logic [DATA_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic [1:0]            c_size;
    logic                  c_sign;
    logic                  c_ack;
    logic [DATA_WIDTH-1:0] c_rdata;
    logic                  c_stall;

    // debug/loader port
    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [1:0]            d_size;
    logic                  d_sign;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    // data_memory command and read return
    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_size;
    logic                  mem_sign;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_size, c_sign,
        output c_ack, c_rdata, c_stall,
        input  d_req, d_we, d_addr, d_wdata, d_size, d_sign,
        output d_ack, d_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_size, c_sign,
        input  c_ack, c_rdata, c_stall,
        output d_req, d_we, d_addr, d_wdata, d_size, d_sign,
        input  d_ack, d_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the core load/store path and the
// debug/loader port: one transaction at a time, round-robin or core-first.
module dmem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter bit CORE_PRIORITY = 1'b0
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    state_t     next_state;
    logic       grant_core;   // owner of the transaction in flight
    logic       last_core;    // last-granted pointer: 1 = core, 0 = debug
    logic       cmd_we;

    logic       mem_re_q;
    logic       mem_we_q;
    word_t      mem_addr_q;
    word_t      mem_wdata_q;
    logic [1:0] mem_size_q;
    logic       mem_sign_q;
    logic       c_ack_q;
    logic       d_ack_q;

    logic       tie_core;
    logic       take;
    logic       take_core;
    logic       sel_we;
    word_t      sel_addr;
    word_t      sel_wdata;
    logic [1:0] sel_size;
    logic       sel_sign;

    // Winner when arbitrating from IDLE, where neither port is masked.
    always_comb begin
        if (bus.c_req && bus.d_req) begin
            tie_core = CORE_PRIORITY ? 1'b1 : ~last_core;
        end else begin
            tie_core = bus.c_req;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        take       = 1'b0;
        take_core  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.c_req || bus.d_req) begin
                    take       = 1'b1;
                    take_core  = tie_core;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                next_state = RESP;
            end
            RESP: begin
                // The current winner's req is still high during its ack, so only the other port competes.
                next_state = IDLE;
                if (grant_core) begin
                    if (bus.d_req && !(CORE_PRIORITY && bus.c_req)) begin
                        take       = 1'b1;
                        take_core  = 1'b0;
                        next_state = ACCESS;
                    end
                end else if (bus.c_req) begin
                    take       = 1'b1;
                    take_core  = 1'b1;
                    next_state = ACCESS;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        if (take_core) begin
            sel_we    = bus.c_we;
            sel_addr  = bus.c_addr;
            sel_wdata = bus.c_wdata;
            sel_size  = bus.c_size;
            sel_sign  = bus.c_sign;
        end else begin
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
            sel_size  = bus.d_size;
            sel_sign  = bus.d_sign;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            grant_core  <= 1'b0;
            last_core   <= 1'b0;
            cmd_we      <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            mem_sign_q  <= 1'b0;
            c_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state    <= next_state;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            c_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;

            if (take) begin
                grant_core  <= take_core;
                last_core   <= take_core;
                cmd_we      <= sel_we;
                mem_re_q    <= ~sel_we;
                mem_we_q    <= sel_we;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
                mem_size_q  <= sel_size;
                mem_sign_q  <= sel_sign;
            end

            if (state == ACCESS) begin
                c_ack_q <= grant_core;
                d_ack_q <= ~grant_core;
            end
        end
    end

    // Read data is steered straight from memory during the ack cycle and forced to zero otherwise.
    assign bus.c_ack   = c_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.c_rdata = (c_ack_q && !cmd_we) ? bus.mem_rdata : '0;
    assign bus.d_rdata = (d_ack_q && !cmd_we) ? bus.mem_rdata : '0;
    assign bus.c_stall = bus.c_req & ~c_ack_q;

    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_sign  = mem_sign_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scoreboard of expected memory commands
// and acks, plus per-scenario latency and ordering checks.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.DATA_WIDTH(W)) bus   ();
    dmem_arbiter_if #(.DATA_WIDTH(W)) bus_p ();

    dmem_arbiter #(.DATA_WIDTH(W), .CORE_PRIORITY(1'b0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    dmem_arbiter #(.DATA_WIDTH(W), .CORE_PRIORITY(1'b1)) dut_p (
        .clock (clock),
        .reset (reset),
        .bus   (bus_p)
    );

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [1:0]   size;
        logic         sign;
    } cmd_t;

    typedef struct {
        logic         is_core;
        logic [W-1:0] rdata;
    } ack_t;

    cmd_t exp_cmd[$];
    ack_t exp_ack[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Memory model: every address reads back as a fixed scramble of itself.
    function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a);
        return a ^ 32'hCEAD_BEFF;
    endfunction

    logic         mem_rd_seen;
    logic [W-1:0] mem_rd_addr;
    initial begin
        bus.mem_rdata   = '1;
        bus_p.mem_rdata = '0;
        forever begin
            @(negedge clock);
            mem_rd_seen = (bus.mem_re === 1'b1);
            mem_rd_addr = bus.mem_addr;
            @(posedge clock);
            #1;
            bus.mem_rdata = mem_rd_seen ? mem_fn(mem_rd_addr) : 32'hFFFF_FFFF;
        end
    end

    // Scoreboard monitor for the round-robin instance.
    cmd_t mc;
    ack_t ma;
    always @(negedge clock) begin
        if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) begin
            tests_run++;
            if (exp_cmd.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_strobe: got re=%0b we=%0b addr=%h, expected no strobe",
                         bus.mem_re, bus.mem_we, bus.mem_addr);
            end else begin
                mc = exp_cmd.pop_front();
                if (bus.mem_re !== ~mc.we || bus.mem_we !== mc.we || bus.mem_addr !== mc.addr ||
                    bus.mem_wdata !== mc.wdata || bus.mem_size !== mc.size || bus.mem_sign !== mc.sign) begin
                    tests_failed++;
                    $display("FAIL mem_cmd: got re=%0b we=%0b addr=%h wdata=%h size=%0d sign=%0b, expected we=%0b addr=%h wdata=%h size=%0d sign=%0b",
                             bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_size, bus.mem_sign,
                             mc.we, mc.addr, mc.wdata, mc.size, mc.sign);
                end
            end
        end
        if (bus.c_ack === 1'b1 && bus.d_ack === 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL both_acks: got c_ack=1 d_ack=1, expected at most one");
        end else if (bus.c_ack === 1'b1 || bus.d_ack === 1'b1) begin
            tests_run++;
            if (exp_ack.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_ack: got c_ack=%0b d_ack=%0b, expected no ack", bus.c_ack, bus.d_ack);
            end else begin
                ma = exp_ack.pop_front();
                if (bus.c_ack !== ma.is_core ||
                    (ma.is_core ? bus.c_rdata : bus.d_rdata) !== ma.rdata) begin
                    tests_failed++;
                    $display("FAIL ack_data: got c_ack=%0b c_rdata=%h d_rdata=%h, expected core=%0b rdata=%h",
                             bus.c_ack, bus.c_rdata, bus.d_rdata, ma.is_core, ma.rdata);
                end
            end
        end
    end

    task automatic push_txn(input logic is_core, input logic we, input logic [W-1:0] addr,
                            input logic [W-1:0] wdata, input logic [1:0] size, input logic sign,
                            input bit with_ack);
        exp_cmd.push_back('{we: we, addr: addr, wdata: wdata, size: size, sign: sign});
        if (with_ack) exp_ack.push_back('{is_core: is_core, rdata: we ? '0 : mem_fn(addr)});
    endtask

    task automatic load_core(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                             input logic [1:0] size, input logic sign);
        bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_size = size; bus.c_sign = sign;
        push_txn(1'b1, we, addr, wdata, size, sign, 1'b1);
    endtask

    task automatic load_dbg(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                            input logic [1:0] size, input logic sign, input bit with_ack);
        bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_size = size; bus.d_sign = sign;
        push_txn(1'b0, we, addr, wdata, size, sign, with_ack);
    endtask

    // Runs until every expected ack has been seen, dropping each req on its ack.
    task automatic drain(input int budget, output int used);
        used = 0;
        while (exp_ack.size() != 0 && used < budget) begin
            @(negedge clock);
            if (bus.c_ack === 1'b1) bus.c_req = 1'b0;
            if (bus.d_ack === 1'b1) bus.d_req = 1'b0;
            used++;
        end
        @(negedge clock);
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic test_reset();
        int used;
        reset = 1'b0;
        load_core(1'b1, 32'h0000_1000, 32'hAAAA_0001, 2'd2, 1'b0);
        load_dbg (1'b1, 32'h0000_2000, 32'hBBBB_0002, 2'd1, 1'b1, 1'b1);
        bus.c_req = 1'b1;
        bus.d_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests_run++;
            if ({bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_size, bus.mem_sign,
                 bus.c_ack, bus.d_ack, bus.c_rdata, bus.d_rdata} !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: got re=%0b we=%0b addr=%h wdata=%h ack=%0b/%0b rdata=%h/%h, expected all 0",
                         i, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.c_ack, bus.d_ack,
                         bus.c_rdata, bus.d_rdata);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0000_1000) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got we=%0b addr=%h, expected we=1 addr=00001000",
                     bus.mem_we, bus.mem_addr);
        end
        drain(20, used);
        tests_run++;
        if (used >= 20) begin
            tests_failed++;
            $display("FAIL reset_drain_timeout: got %0d cycles, expected fewer than 20", used);
        end
    endtask

    task automatic test_core_load();
        load_core(1'b0, 32'h1000_0010, 32'h0, 2'd2, 1'b0);
        @(negedge clock);
        bus.c_req = 1'b1;
        #1;
        tests_run++;
        if (bus.c_stall !== 1'b1 || bus.mem_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_cycle_n: got stall=%0b re=%0b, expected stall=1 re=0", bus.c_stall, bus.mem_re);
        end
        @(negedge clock);
        tests_run++;
        if (bus.mem_re !== 1'b1 || bus.c_stall !== 1'b1 || bus.c_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_cycle_n1: got re=%0b stall=%0b ack=%0b, expected re=1 stall=1 ack=0",
                     bus.mem_re, bus.c_stall, bus.c_ack);
        end
        @(negedge clock);
        tests_run++;
        if (bus.c_ack !== 1'b1 || bus.c_rdata !== 32'hDEAD_BEEF || bus.c_stall !== 1'b0 || bus.mem_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_cycle_n2: got ack=%0b rdata=%h stall=%0b re=%0b, expected ack=1 rdata=deadbeef stall=0 re=0",
                     bus.c_ack, bus.c_rdata, bus.c_stall, bus.mem_re);
        end
        bus.c_req = 1'b0;
        @(negedge clock);
        tests_run++;
        if (bus.c_ack !== 1'b0 || bus.c_rdata !== '0) begin
            tests_failed++;
            $display("FAIL load_after_ack: got ack=%0b rdata=%h, expected ack=0 rdata=0", bus.c_ack, bus.c_rdata);
        end
    endtask

    // Core was granted last, so the debug port wins the opening tie: D, C, D, C.
    task automatic test_round_robin();
        int ack_cyc[$];
        int exp_cyc[4] = '{2, 4, 6, 8};
        logic exp_core[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic who[$];
        int nc = 0;
        int nd = 0;
        bit bad;
        load_dbg (1'b1, 32'h2000_0000, 32'h1111_0000, 2'd2, 1'b0, 1'b1);
        load_core(1'b1, 32'h3000_0000, 32'h2222_0000, 2'd0, 1'b1);
        bus.c_req = 1'b1;
        bus.d_req = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            if (bus.d_ack === 1'b1) begin
                ack_cyc.push_back(cyc); who.push_back(1'b0); nd++;
                if (nd == 1) load_dbg(1'b1, 32'h2000_0004, 32'h1111_0001, 2'd2, 1'b0, 1'b1);
                else bus.d_req = 1'b0;
            end
            if (bus.c_ack === 1'b1) begin
                ack_cyc.push_back(cyc); who.push_back(1'b1); nc++;
                if (nc == 1) load_core(1'b1, 32'h3000_0004, 32'h2222_0001, 2'd1, 1'b0);
                else bus.c_req = 1'b0;
            end
        end
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        bad = (ack_cyc.size() != 4);
        for (int i = 0; i < ack_cyc.size() && i < 4; i++)
            if (ack_cyc[i] != exp_cyc[i] || who[i] !== exp_core[i]) bad = 1'b1;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL rr_ack_timing: got %0d acks at %p by core=%p, expected cycles 2,4,6,8 by D,C,D,C",
                     ack_cyc.size(), ack_cyc, who);
        end
    endtask

    task automatic test_back_to_back();
        int ack_cyc[$];
        int nd = 0;
        load_dbg(1'b0, 32'h4000_0040, 32'h0, 2'd2, 1'b1, 1'b1);
        @(negedge clock);
        bus.d_req = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            tests_run++;
            if (bus.c_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_core_ack: got c_ack=%0b at cycle %0d, expected 0", bus.c_ack, cyc);
            end
            if (bus.d_ack === 1'b1) begin
                ack_cyc.push_back(cyc); nd++;
                if (nd == 1) load_dbg(1'b0, 32'h4000_0080, 32'h0, 2'd0, 1'b0, 1'b1);
                else bus.d_req = 1'b0;
            end
        end
        bus.d_req = 1'b0;
        tests_run++;
        if (ack_cyc.size() != 2 || ack_cyc[0] != 2 || ack_cyc[1] != 5) begin
            tests_failed++;
            $display("FAIL b2b_timing: got acks at %p, expected cycles 2,5", ack_cyc);
        end
    endtask

    task automatic test_command_sampling();
        load_core(1'b0, 32'h0000_0010, 32'h5555_0000, 2'd1, 1'b1);
        @(negedge clock);
        bus.c_req = 1'b1;
        @(negedge clock);
        bus.c_addr  = 32'h0000_0020;
        bus.c_wdata = 32'h6666_0000;
        bus.c_sign  = 1'b0;
        tests_run++;
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL sample_access: got re=%0b addr=%h, expected re=1 addr=00000010", bus.mem_re, bus.mem_addr);
        end
        @(negedge clock);
        tests_run++;
        if (bus.c_ack !== 1'b1 || bus.c_rdata !== mem_fn(32'h0000_0010) || bus.mem_addr !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL sample_ack: got ack=%0b rdata=%h addr=%h, expected ack=1 rdata=%h addr=00000010",
                     bus.c_ack, bus.c_rdata, bus.mem_addr, mem_fn(32'h0000_0010));
        end
        bus.c_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mid_reset();
        int used;
        load_dbg(1'b1, 32'h5000_0000, 32'h7777_0000, 2'd2, 1'b0, 1'b0);
        @(negedge clock);
        bus.d_req = 1'b1;
        @(negedge clock);
        tests_run++;
        if (bus.mem_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_access: got we=%0b, expected 1", bus.mem_we);
        end
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.d_ack !== 1'b0 || bus.mem_addr !== '0 || bus.d_rdata !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got we=%0b re=%0b d_ack=%0b addr=%h, expected all 0",
                     bus.mem_we, bus.mem_re, bus.d_ack, bus.mem_addr);
        end
        reset = 1'b1;
        bus.d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tests_run++;
            if (bus.d_ack !== 1'b0 || bus.c_ack !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_quiet[%0d]: got acks=%0b/%0b strobes=%0b/%0b, expected all 0",
                         i, bus.c_ack, bus.d_ack, bus.mem_re, bus.mem_we);
            end
        end
        // Pointer is back at debug, so the core takes the next tie.
        load_core(1'b1, 32'h5000_0100, 32'h8888_0000, 2'd2, 1'b0);
        load_dbg (1'b1, 32'h5000_0200, 32'h9999_0000, 2'd2, 1'b0, 1'b1);
        bus.c_req = 1'b1;
        bus.d_req = 1'b1;
        drain(20, used);
        tests_run++;
        if (used >= 20) begin
            tests_failed++;
            $display("FAIL midrst_drain_timeout: got %0d cycles, expected fewer than 20", used);
        end
    endtask

    task automatic test_priority();
        int c_cyc[$];
        int d_cyc = -1;
        int strobes = 0;
        bus_p.c_we = 1'b1; bus_p.c_addr = 32'h6000_0000; bus_p.c_wdata = 32'h1; bus_p.c_size = 2'd2; bus_p.c_sign = 1'b0;
        bus_p.d_we = 1'b1; bus_p.d_addr = 32'h7000_0000; bus_p.d_wdata = 32'h2; bus_p.d_size = 2'd2; bus_p.d_sign = 1'b0;
        @(negedge clock);
        bus_p.c_req = 1'b1;
        bus_p.d_req = 1'b1;
        for (int cyc = 1; cyc <= 30 && d_cyc < 0; cyc++) begin
            @(negedge clock);
            if (bus_p.mem_we === 1'b1) strobes++;
            if (bus_p.d_ack === 1'b1) begin
                d_cyc = cyc;
                bus_p.d_req = 1'b0;
            end
            if (bus_p.c_ack === 1'b1) begin
                c_cyc.push_back(cyc);
                if (c_cyc.size() == 4) bus_p.c_req = 1'b0;
            end
        end
        bus_p.c_req = 1'b0;
        bus_p.d_req = 1'b0;
        tests_run++;
        if (c_cyc.size() != 4 || c_cyc[0] != 2 || c_cyc[1] != 5 || c_cyc[2] != 8 || c_cyc[3] != 11) begin
            tests_failed++;
            $display("FAIL prio_core_acks: got %p, expected cycles 2,5,8,11", c_cyc);
        end
        tests_run++;
        if (d_cyc != 13) begin
            tests_failed++;
            $display("FAIL prio_debug_ack: got cycle %0d, expected 13 (after core drops)", d_cyc);
        end
        tests_run++;
        if (strobes != 5) begin
            tests_failed++;
            $display("FAIL prio_strobes: got %0d, expected 5", strobes);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_size = '0; bus.c_sign = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0; bus.d_sign = 1'b0;
        bus_p.c_req = 1'b0; bus_p.c_we = 1'b0; bus_p.c_addr = '0; bus_p.c_wdata = '0; bus_p.c_size = '0; bus_p.c_sign = 1'b0;
        bus_p.d_req = 1'b0; bus_p.d_we = 1'b0; bus_p.d_addr = '0; bus_p.d_wdata = '0; bus_p.d_size = '0; bus_p.d_sign = 1'b0;

        test_reset();
        test_core_load();
        test_round_robin();
        test_back_to_back();
        test_command_sampling();
        test_mid_reset();
        test_priority();

        repeat (3) @(negedge clock);
        tests_run++;
        if (exp_cmd.size() != 0 || exp_ack.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover: got %0d cmds %0d acks pending, expected 0 0",
                     exp_cmd.size(), exp_ack.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000ns, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data_memory port, including its memory-mapped serial I/O, between the processor core's load/store path and a debug/loader port. It serialises requests, chooses between them round-robin (or core-first when configured), and returns read data with a one-cycle acknowledge pulse. It sits between the core's ALU/regfile outputs and data_memory. The core stalls its PC update while its request is pending and not yet acknowledged.

## Interface
- DATA_WIDTH, 32, width of addresses, write data and read data.
- CORE_PRIORITY, 0, 0 = round-robin; 1 = core always wins simultaneous requests.
- clock  input  1  clock
- reset  input  1  synchronous, active-low reset
- c_req  input  1  core request; held high until c_ack.
- c_we  input  1  1 = store, 0 = load.
- c_addr, c_wdata  input  DATA_WIDTH  core address and store data.
- c_size  input  2  access size, passed through to memory.
- c_sign  input  1  load sign-extend flag, passed through.
- c_ack  output  1  one-cycle completion pulse to the core.
- c_rdata  output  DATA_WIDTH  load data; valid only while c_ack is high.
- c_stall  output  1  equals c_req & ~c_ack (combinational).
- d_req, d_we, d_addr, d_wdata, d_size, d_sign, d_ack, d_rdata  same directions, widths and meanings as the c_* ports, for the debug port.
- mem_re, mem_we  output  1  memory strobes (registered).
- mem_addr, mem_wdata  output  DATA_WIDTH  registered memory command.
- mem_size  output  2  registered.
- mem_sign  output  1  registered.
- mem_rdata  input  DATA_WIDTH  memory read data; valid the cycle after mem_re.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset enters IDLE.
- **IDLE:** if any request is asserted, arbitrate at the clock edge, latch the winner's command into the mem_* registers, record the winner, and go to ACCESS. Otherwise stay in IDLE.
- **ACCESS:** mem_re = ~we or mem_we = we of the winner. Exactly one strobe is high for exactly one cycle. Next state is RESP unconditionally.
- **RESP:**
  - The winner's ack is high.
  - For a load, the winner's rdata = mem_rdata. For a store, rdata = 0.
  - Strobes are low.
  - Arbitration for the next transaction happens this same edge. The winner's req is masked out because it is still legally high during its ack.
  - If the other port requests, latch it and go to ACCESS. Otherwise go to IDLE.
- **Round-robin:** on a simultaneous request, the port not granted last wins. The last-granted pointer resets to debug, so the core wins the first tie.
- **CORE_PRIORITY=1:** the core wins every tie. The debug port is served only when c_req is low at arbitration time.
- Request fields are sampled only at the arbitration edge. Changes afterwards have no effect on the current transaction.
- A requester must not drop req before its ack. If it does, the transaction still completes and the ack still pulses.
- c_ack and d_ack are never high in the same cycle.

## Timing
- **Reset values:**
  - state = IDLE.
  - mem_re = mem_we = 0.
  - mem_addr, mem_wdata, mem_size, mem_sign = 0.
  - c_ack = d_ack = 0.
  - c_rdata = d_rdata = 0.
  - Last-granted pointer = debug.
- **Reset mid-transaction:** returns to IDLE on the next edge with all outputs at reset values. The pending transaction is abandoned with no ack, and any strobe drops.
- **Latency:** req rises in cycle N with the FSM in IDLE. mem strobe is high in N+1. ack and rdata are valid in N+2.
- **Minimum spacing:** 2 cycles between acks under continuous contention (ACCESS, RESP, ACCESS, ...).
- **Back-to-back same port:** a port that re-asserts req immediately after its ack is seen at the next IDLE or RESP edge. It gets the earliest ack at N+2 relative to its new request cycle.
- **c_stall:** high from req assertion until the ack cycle, low in the ack cycle.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with both req=1 -> all outputs 0 and no strobe; release -> core granted first, mem_addr = c_addr one cycle later.
- **Single core load:** c_req, c_we=0, c_addr=0x1000_0010, mem_rdata=0xDEAD_BEEF in ACCESS+1 -> mem_re high in N+1, c_ack and c_rdata=0xDEAD_BEEF in N+2, c_stall high in N and N+1.
- **Contention, round-robin:** both ports request continuously with stores -> grants alternate C, D, C, D; acks at N+2, N+4, N+6, N+8; no two acks in the same cycle.
- **CORE_PRIORITY=1:** c_req held high for 4 transactions while d_req stays high -> d_ack only after c_req drops.
- **Mid-transaction reset:** assert reset in the ACCESS cycle of a debug store -> no d_ack, mem_we=0 the next cycle, FSM in IDLE.
- **Command sampling:** change c_addr from 0x10 to 0x20 during ACCESS -> memory sees 0x10 only; ack returns as normal.
